// File: rtl/pct_pkg.sv
// rtl/pct_pkg.sv - shared PCT widths, entry field offsets and arbiter encodings
package pct_pkg;

    localparam int DEF_PID_BIT    = 10;
    localparam int DEF_DATA_W     = 134;
    localparam int DEF_STARVE_MAX = 4;

    // PCT entry layout: {br_cnt, br_done_flag, ct, ht}
    localparam int BRCNT_MSB = 133;
    localparam int BRCNT_W   = 5;
    localparam int DONE_BIT  = 128;
    localparam int CT_MSB    = 127;
    localparam int HT_MSB    = 63;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_RDRESP = 3'd3,
        ST_CLEAR  = 3'd4
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/pct_arbiter.sv
// rtl/pct_arbiter.sv - single-port PCT SRAM arbiter, port A priority with starvation guard for B
// Optional feature macro: PCT_ARB_INIT_CLEAR_EN (zero-fills the table after reset release).
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request, held until a_gnt
//   a_gnt, a_rvalid, a_rdata   port A grant pulse, read-valid pulse, read data (held)
//   b_*                        port B, same semantics as port A
//   mem_en/mem_we/mem_addr/mem_wdata  SRAM controls; mem_rdata valid the cycle after a read
//   busy                       transaction in flight or clear sweep active
module pct_arbiter
    import pct_pkg::*;
#(
    parameter int PID_bit    = DEF_PID_BIT,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [PID_bit-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [PID_bit-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [PID_bit-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

`ifdef PCT_ARB_INIT_CLEAR_EN
    localparam arb_state_e RESET_STATE = ST_CLEAR;
`else
    localparam arb_state_e RESET_STATE = ST_IDLE;
`endif

    arb_state_e         state_q, state_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               id_q, id_d;
    logic               a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic               a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [PID_bit-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               busy_q, busy_d;
    logic               arb_slot;
    logic               grant_now;
    logic               pick_b;
`ifdef PCT_ARB_INIT_CLEAR_EN
    logic [PID_bit-1:0] clr_addr_q, clr_addr_d;
`endif

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        id_d        = id_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PCT_ARB_INIT_CLEAR_EN
        clr_addr_d  = clr_addr_q;
`endif

        // Arbitration only happens when the SRAM port is free next cycle.
        arb_slot  = (state_q == ST_IDLE) || (state_q == ST_RDRESP);
        grant_now = arb_slot && (a_req || b_req);
        pick_b    = b_req && (!a_req || (starve_q == SW'(STARVE_MAX)));

        case (state_q)
            ST_IDLE, ST_RDRESP: begin
                if (grant_now) begin
                    state_d  = ST_GRANT;
                    id_d     = pick_b ? PORT_B : PORT_A;
                    mem_en_d = 1'b1;
                    if (pick_b) begin
                        b_gnt_d     = 1'b1;
                        mem_we_d    = b_we;
                        mem_addr_d  = b_addr;
                        mem_wdata_d = b_wdata;
                    end else begin
                        a_gnt_d     = 1'b1;
                        mem_we_d    = a_we;
                        mem_addr_d  = a_addr;
                        mem_wdata_d = a_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // mem_we_q is the winner's direction, copied on entry.
                state_d = mem_we_q ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                state_d = ST_RDRESP;
                if (id_q == PORT_B) begin
                    b_rdata_d  = mem_rdata;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = mem_rdata;
                    a_rvalid_d = 1'b1;
                end
            end
`ifdef PCT_ARB_INIT_CLEAR_EN
            ST_CLEAR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_addr_q;
                mem_wdata_d = '0;
                clr_addr_d  = clr_addr_q + 1'b1;
                if (clr_addr_q == {PID_bit{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!b_req) begin
            starve_d = '0;
        end else if (grant_now && !pick_b) begin
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
        end else if (grant_now && pick_b) begin
            starve_d = '0;
        end

        // The final sweep write goes out while the state already reads IDLE.
        busy_d = (state_d != ST_IDLE) || (state_q == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RESET_STATE;
            starve_q    <= '0;
            id_q        <= PORT_A;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            id_q        <= id_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

`ifdef PCT_ARB_INIT_CLEAR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clr_addr_q <= '0;
        end else begin
            clr_addr_q <= clr_addr_d;
        end
    end
`endif

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

    // A request may only fall once its grant has been seen.
    a_req_held: assert property (@(posedge clk) disable iff (!resetn)
        $fell(a_req) |-> (a_gnt_q || $past(a_gnt_q)));
    b_req_held: assert property (@(posedge clk) disable iff (!resetn)
        $fell(b_req) |-> (b_gnt_q || $past(b_gnt_q)));

endmodule

// File: tb/tb_pct_arbiter.sv
// tb/tb_pct_arbiter.sv - self-checking bench for pct_arbiter with SRAM model and scoreboard
module tb_pct_arbiter;
    import pct_pkg::*;

`ifdef PCT_ARB_INIT_CLEAR_EN
    localparam int PB = 4;
`else
    localparam int PB = 10;
`endif
    localparam int DW   = 134;
    localparam int SMAX = 4;

    typedef struct {
        logic          we;
        logic [PB-1:0] addr;
        logic [DW-1:0] data;
        int            delay;
    } txn_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          a_req, a_we, b_req, b_we;
    logic [PB-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we, busy;
    logic [PB-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    pct_arbiter #(.PID_bit(PB), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM model: unwritten words read as zero.
    logic [DW-1:0]      sram [0:(1<<PB)-1];
    logic [(1<<PB)-1:0] written;
    logic               sram_clr;
    always @(posedge clk) begin
        if (sram_clr) begin
            written <= '0;
        end else if (mem_en && mem_we) begin
            sram[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= written[mem_addr] ? sram[mem_addr] : '0;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [DW-1:0] ref_mem [int];
    txn_t          qa[$], qb[$];
    int            log_port[$], log_cyc[$];
    int            cyc = 0;
    int            st = 0;
    bit            app_a, app_b, prev_gnt;
    bit            rd_pend;
    int            rd_port, rd_cyc;
    logic [DW-1:0] rd_data, last_a, last_b;

    localparam logic [DW-1:0] W0 = {5'd3, 1'b0, 64'hA, 64'hB};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    function automatic txn_t mk(input bit we, input int addr, input logic [DW-1:0] data, input int delay);
        txn_t t;
        t.we    = we;
        t.addr  = addr[PB-1:0];
        t.data  = data;
        t.delay = delay;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [159:0] r;
        int           addr;
        r    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        addr = ($urandom_range(0, 9) < 3) ? (1 << PB) - 1 : int'($urandom_range(0, 7));
        return mk($urandom_range(0, 1) == 1, addr, r[DW-1:0],
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    endfunction

    task automatic drive_port(inout txn_t q[$], output logic req, output logic we,
                              output logic [PB-1:0] addr, output logic [DW-1:0] wdata);
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        if (q.size() > 0) begin
            if (q[0].delay > 0) begin
                q[0].delay = q[0].delay - 1;
            end else begin
                req = 1'b1; we = q[0].we; addr = q[0].addr; wdata = q[0].data;
            end
        end
    endtask

    // Cycle-level requester driver plus scoreboard; sampled and driven at negedge.
    task automatic run(input int budget);
        int   n = 0;
        bit   done = 0;
        bit   timed_out = 0;
        bit   ga, gb, w, expw, exp_av, exp_bv;
        txn_t t;
        log_port.delete();
        log_cyc.delete();
        app_a = a_req;
        app_b = b_req;
        while (!done) begin
            @(negedge clk);
            cyc++;
            n++;
            ga = a_gnt;
            gb = b_gnt;
            chk("gnt_exclusive", ga & gb, 0);
            if (prev_gnt) begin
                chk("gnt_one_cycle", {ga, gb}, 0);
                chk("mem_en_one_cycle", mem_en, 0);
            end
            if (ga || gb) begin
                w    = gb;
                expw = app_b && (!app_a || st == SMAX);
                chk("winner", w, expw);
                chk("grant_had_req", w ? app_b : app_a, 1);
                if ((w && qb.size() > 0) || (!w && qa.size() > 0)) begin
                    t = w ? qb.pop_front() : qa.pop_front();
                    chk("grant_mem_en", mem_en, 1);
                    chk("grant_mem_we", mem_we, t.we);
                    chk("grant_mem_addr", mem_addr, t.addr);
                    chk("grant_busy", busy, 1);
                    if (t.we) begin
                        chk("grant_mem_wdata", mem_wdata, t.data);
                        ref_mem[int'(t.addr)] = t.data;
                    end else begin
                        rd_pend = 1;
                        rd_port = w;
                        rd_cyc  = cyc + 2;
                        rd_data = ref_mem.exists(int'(t.addr)) ? ref_mem[int'(t.addr)] : '0;
                    end
                end
                log_port.push_back(int'(w));
                log_cyc.push_back(cyc);
            end
            if (!app_b) st = 0;
            else if (ga) st = (st < SMAX) ? st + 1 : SMAX;
            else if (gb) st = 0;
            exp_av = rd_pend && rd_cyc == cyc && rd_port == 0;
            exp_bv = rd_pend && rd_cyc == cyc && rd_port == 1;
            chk("a_rvalid", a_rvalid, exp_av);
            chk("b_rvalid", b_rvalid, exp_bv);
            if (exp_av) last_a = rd_data;
            if (exp_bv) last_b = rd_data;
            chk("a_rdata", a_rdata, last_a);
            chk("b_rdata", b_rdata, last_b);
            if (rd_pend && rd_cyc == cyc) rd_pend = 0;
            prev_gnt = ga || gb;
            drive_port(qa, a_req, a_we, a_addr, a_wdata);
            drive_port(qb, b_req, b_we, b_addr, b_wdata);
            app_a = a_req;
            app_b = b_req;
            done = qa.size() == 0 && qb.size() == 0 && !rd_pend && !prev_gnt;
            if (!done && n >= budget) begin
                timed_out = 1;
                done = 1;
            end
        end
        chk("run_timeout", timed_out, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {a_gnt, b_gnt}, 0);
        chk({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
        chk({tag, "_mem_ctl"}, {mem_en, mem_we}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

`ifdef PCT_ARB_INIT_CLEAR_EN
    task automatic clear_sweep(input bit with_req);
        for (int i = 0; i < (1 << PB); i++) begin
            @(negedge clk);
            chk("clr_mem_en_we", {mem_en, mem_we}, 2'b11);
            chk("clr_addr", mem_addr, i[PB-1:0]);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_busy", busy, 1);
            chk("clr_no_gnt", {a_gnt, b_gnt}, 0);
            if (with_req && i == 2) begin
                a_req = 1'b1; a_we = 1'b1; a_addr = PB'(5); a_wdata = W0;
            end
        end
        ref_mem.delete();
        if (with_req) begin
            @(negedge clk);
            chk("post_clr_gnt", a_gnt, 1);
            chk("post_clr_addr", mem_addr, PB'(5));
            a_req = 1'b0;
            ref_mem[5] = W0;
            @(negedge clk);
            chk("post_clr_gnt_drop", a_gnt, 0);
        end
    endtask
`endif

    int pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int c0;

    initial begin
        resetn = 1'b0; sram_clr = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        last_a = '0; last_b = '0; rd_pend = 0; prev_gnt = 0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        sram_clr = 1'b0;
        resetn = 1'b1;
`ifdef PCT_ARB_INIT_CLEAR_EN
        clear_sweep(1);
`else
        @(negedge clk);
        chk("idle_busy", busy, 0);
`endif

        // Single A write, then read back
        c0 = cyc;
        qa.push_back(mk(1, 'h15, W0, 0));
        run(50);
        chk("wr_latency", log_cyc[0] - c0, 2);
        chk("wr_port", log_port[0], 0);
        qa.push_back(mk(0, 'h15, '0, 0));
        run(50);
        chk("rd_data", a_rdata, W0);
        chk("rd_b_rdata_untouched", b_rdata, 0);

        // Both ports saturated: starvation guard
        for (int i = 0; i < 10; i++) qa.push_back(mk(1, 32 + i, DW'(i + 100), 0));
        for (int i = 0; i < 4; i++)  qb.push_back(mk(1, 64 + i, DW'(i + 200), 0));
        run(200);
        for (int i = 0; i < 10; i++) chk($sformatf("starve_seq%0d", i), log_port[i], pat[i]);

        // Concurrent A read and B write: B waits for the RDRESP arbitration
        c0 = cyc;
        qa.push_back(mk(0, 0, '0, 0));
        qb.push_back(mk(1, 'h3FF, W0 ^ {DW{1'b1}}, 0));
        run(50);
        chk("conc_first", log_port[0], 0);
        chk("conc_second", log_port[1], 1);
        chk("conc_b_cycle", log_cyc[1] - c0, 5);

        // Reset during RDWAIT of an A read
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = PB'('h15);
        @(negedge clk);
        chk("rst_pre_gnt", a_gnt, 1);
        a_req = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        st = 0; last_a = '0; last_b = '0; rd_pend = 0; prev_gnt = 0;
`ifdef PCT_ARB_INIT_CLEAR_EN
        clear_sweep(0);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rvalid", {a_rvalid, b_rvalid}, 0);
        end
        qa.push_back(mk(0, 'h15, '0, 0));
        run(50);

        // Randomized mixed traffic
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) begin
                qa.push_back(rand_txn());
                qb.push_back(rand_txn());
            end
            run(1500);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pct_arbiter.md
Name: pct_arbiter

Overview:
- Arbitrates the single-port Process Context Table (PCT) SRAM between two requesters.
- Port A is the top-level LSTM control FSM; it issues save/load of {br_cnt, br_done_flag, ct, ht} per PID.
- Port B is the host/maintenance port, used for context flush, inspection and preload.
- The block owns every SRAM control signal. It returns read data with a valid pulse, applies fixed priority to A with a starvation guard for B, and optionally clears the table after reset.

Parameters:
- PID_bit, 10, PCT address width (2^PID_bit entries).
- DATA_W, 134, PCT entry width: [133:129] br_cnt, [128] br_done_flag, [127:64] ct, [63:0] ht.
- STARVE_MAX, 4, consecutive A grants allowed while B is pending before B is forced.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt
- a_we  in  1  1=write, 0=read
- a_addr  in  PID_bit  entry address
- a_wdata  in  DATA_W  write data
- a_gnt  out  1  one-cycle grant pulse
- a_rvalid  out  1  one-cycle read-data valid
- a_rdata  out  DATA_W  read data, held until the next A read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B, identical semantics to port A
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  PID_bit  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en && !mem_we
- busy  out  1  transaction in flight or clear sweep active

Behaviour:
- Reset: all outputs 0 (gnt, rvalid, rdata, mem_*, busy); state=IDLE (CLEAR if feature on); starve_cnt=0.
- Reset mid-operation aborts any transaction. There is no retry; requesters are reset too.
- All outputs are registered.
- States: IDLE, GRANT, RDWAIT, RDRESP (plus CLEAR with the optional feature).
- Arbitration is evaluated in IDLE and RDRESP only.
  - Winner: A, unless (b_req && (!a_req || starve_cnt==STARVE_MAX)).
- Entering GRANT (next edge): winner's gnt=1, mem_en=1, mem_we/addr/wdata copied from winner; busy=1; winner id latched.
- GRANT -> IDLE if write; GRANT -> RDWAIT if read.
  - mem_en and gnt drop after exactly one cycle.
- RDWAIT: latch mem_rdata into the winner's rdata at the end of the cycle; -> RDRESP.
- RDRESP: winner's rvalid=1 for one cycle; busy=0 unless a new grant is issued.
- Latency:
  - write: req seen at edge N -> gnt and mem_en during cycle N+1.
  - read: rvalid during cycle N+3.
  - Throughput: one write per 2 cycles; one read per 3 cycles (back-to-back via RDRESP).
- Requesters sample gnt and must deassert or change req on the following edge. The block never grants during GRANT or RDWAIT.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) on each A grant while b_req=1.
  - Cleared on a B grant or when b_req=0.
- Simultaneous a_req & b_req with starve_cnt<STARVE_MAX: A wins.
- Dropping req before gnt is illegal (asserted in simulation); the block's behaviour in that case is undefined.
- a_rdata/b_rdata change only on their own read completion.

Optional Feature:
- Macro: PCT_ARB_INIT_CLEAR_EN.
- Defined: after reset release, the block enters CLEAR and writes 0 to every address, 0..2^PID_bit-1, one per cycle.
  - Signals during CLEAR: mem_en=mem_we=1, busy=1, no grants. Requests are held pending.
  - After the last address, the block returns to IDLE; no wrap.
  - Sweep length: 2^PID_bit cycles.
- Undefined: starts in IDLE; busy=0 after reset; table contents are the SRAM's own.

Decomposition:
- Shared package pct_pkg:
  - PID_bit and DATA_W defaults.
  - Field offsets: BRCNT_MSB=133, BRCNT_W=5, DONE_BIT=128, CT_MSB=127, HT_MSB=63.
  - Arbiter state encoding and the port id constants A=0, B=1.
- No sub-module. The block is flat; the SRAM (pct_sram) stays outside.

Test Plan:
- A write 0x15 with data {5'd3,1'b0,64'hA,64'hB}, B idle -> a_gnt and mem_en/mem_we/mem_addr=0x15 in cycle N+1, exactly one cycle; no rvalid.
- A read 0x15 after that write -> a_rvalid in cycle N+3, a_rdata=the written word; b_rvalid stays 0.
- a_req and b_req held continuously, STARVE_MAX=4 -> grant sequence A,A,A,A,B,A,A,A,A,B.
- B write 0x3FF concurrent with A read 0x000 (starve_cnt=0) -> A served first. B granted at the RDRESP arbitration; mem_addr=0x3FF on the next GRANT.
- resetn low during RDWAIT of an A read -> all outputs 0 immediately; no a_rvalid after release; a new A read completes normally.
- PCT_ARB_INIT_CLEAR_EN, PID_bit=4 -> 16 consecutive zero writes to addresses 0..15 with busy=1; an a_req asserted during the sweep is granted the cycle after the sweep ends.
